tb_capture_ctrl: RTL and testbench

//  Sequences a capture run on the extension test harness. Gates the stimulus stream into the DUT
//  (drives source_mm2s_tready) and frames the free-running DUT output into fixed-length packets on
//  the sink S2MM AXI-Stream, with tlast on every frame boundary. Absorbs S2MM backpressure in a

---
 rtl/tb_capture_pkg.sv | 21 ++
 rtl/capture_fifo.sv | 51 +++++
 rtl/tb_capture_ctrl.sv | 176 +++++++++++++++++
 tb/tb_tb_capture_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tb_capture_pkg.sv
// Shared definitions for the capture controller: FSM state encoding and
// elaboration-time legality checks for the FIFO depth and stream widths.
package tb_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // One entry is held back for tlast beats, so fewer than 4 leaves no useful body space.
    function automatic bit depth_ok(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit widths_ok(input int dw, input int len_w, input int cnt_w);
        return (dw >= 8) && (dw % 8 == 0) && (len_w >= 1) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous show-ahead FIFO of {tlast, tdata} entries with an occupancy count.
// Push and pop in the same cycle are both honoured, including when full.
module capture_fifo #(
    parameter  int W     = 33,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  rd_data_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign do_pop    = pop_i && (count_q != '0);
    assign do_push   = push_i && ((count_q != FULL) || do_pop);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // NOTE: storage has no reset; validity is carried entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tb_capture_ctrl.sv
// Capture-run sequencer: gates stimulus, skips pipeline latency, frames the free-running
// DUT output into tlast-delimited packets and drops what the S2MM side cannot absorb.
module tb_capture_ctrl
    import tb_capture_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int LEN_W = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  skip_len,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [CNT_W-1:0]  num_frames,
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    output logic              stim_en,
    output logic [DW-1:0]     m_axis_tdata,
    output logic [DW/8-1:0]   m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] BODY_LIMIT = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] FULL       = (AW + 1)'(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("tb_capture_ctrl: DEPTH must be a power of 2 and >= 4");
    end
    if (!widths_ok(DW, LEN_W, CNT_W)) begin : g_bad_width
        $error("tb_capture_ctrl: DW must be a multiple of 8; LEN_W and CNT_W must be >= 1");
    end

    state_t            state_q;
    logic [LEN_W-1:0]  skip_len_q, frame_len_q, sample_cnt_q;
    logic [CNT_W-1:0]  num_frames_q, frame_cnt_q, frame_cnt_nxt;
    logic [DW-1:0]     last_data_q;
    logic              stim_en_q, busy_q, done_q, overflow_q;

    logic              is_last, beat_req, beat_last, drop;
    logic [DW-1:0]     beat_data;
    logic              fifo_push, fifo_pop;
    logic [DW:0]       fifo_rdata;
    logic [AW:0]       fifo_count;

    // Beat selection: a tlast beat (frame end or abort tail) may use the reserved entry.
    always_comb begin
        is_last       = (sample_cnt_q == frame_len_q - LEN_W'(1));
        frame_cnt_nxt = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + CNT_W'(1);
        beat_req      = 1'b0;
        beat_last     = 1'b0;
        beat_data     = in_data;
        if (state_q == CAPTURE) begin
            if (in_valid) begin
                if (is_last || (abort && sample_cnt_q != '0)) begin
                    beat_req  = 1'b1;
                    beat_last = 1'b1;
                end else if (!abort) begin
                    beat_req  = 1'b1;
                end
            end else if (abort && sample_cnt_q != '0) begin
                beat_req  = 1'b1;
                beat_last = 1'b1;
                beat_data = last_data_q;
            end
        end
        fifo_push = beat_req && (beat_last ? (fifo_count != FULL) : (fifo_count < BODY_LIMIT));
        drop      = beat_req && !fifo_push;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            skip_len_q   <= '0;
            frame_len_q  <= '0;
            num_frames_q <= '0;
            sample_cnt_q <= '0;
            frame_cnt_q  <= '0;
            last_data_q  <= '0;
            stim_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (fifo_push) last_data_q <= beat_data;
            if (drop)      overflow_q  <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        skip_len_q   <= skip_len;
                        frame_len_q  <= (frame_len == '0) ? LEN_W'(1) : frame_len;
                        num_frames_q <= num_frames;
                        sample_cnt_q <= '0;
                        frame_cnt_q  <= '0;
                        overflow_q   <= 1'b0;
                        stim_en_q    <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= (skip_len == '0) ? CAPTURE : SKIP;
                    end
                end
                SKIP: begin
                    if (abort) begin
                        stim_en_q <= 1'b0;
                        state_q   <= DRAIN;
                    end else if (in_valid) begin
                        if (sample_cnt_q == skip_len_q - LEN_W'(1)) begin
                            sample_cnt_q <= '0;
                            state_q      <= CAPTURE;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + LEN_W'(1);
                        end
                    end
                end
                CAPTURE: begin
                    if (in_valid) begin
                        if (is_last) begin
                            sample_cnt_q <= '0;
                            frame_cnt_q  <= frame_cnt_nxt;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + LEN_W'(1);
                        end
                    end
                    if (abort || (in_valid && is_last && num_frames_q != '0 &&
                                  frame_cnt_nxt == num_frames_q)) begin
                        stim_en_q <= 1'b0;
                        state_q   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_count == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    capture_fifo #(
        .W     (DW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i ({beat_last, beat_data}),
        .pop_i       (fifo_pop),
        .rd_data_o   (fifo_rdata),
        .count_o     (fifo_count)
    );

    assign m_axis_tvalid = (fifo_count != '0);
    assign fifo_pop      = m_axis_tvalid && m_axis_tready;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_rdata[DW-1:0] : '0;
    assign m_axis_tlast  = m_axis_tvalid && fifo_rdata[DW];
    assign m_axis_tkeep  = m_axis_tvalid ? '1 : '0;

    assign stim_en   = stim_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tb_capture_ctrl.sv
// Directed bench for tb_capture_ctrl: ramp stimulus, hand-computed beat lists,
// and a monitor that checks AXI-Stream hold-while-stalled behaviour.
module tb_tb_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort, in_valid, m_axis_tready;
    logic [15:0] skip_len, frame_len, num_frames;
    logic [31:0] in_data;
    logic        stim_en, m_axis_tlast, m_axis_tvalid, busy, done, overflow;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic [15:0] frame_cnt;

    int          checks = 0;
    int          errors = 0;
    int          done_seen = 0;
    logic [32:0] beats[$];
    logic [32:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat;

    tb_capture_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .skip_len      (skip_len),
        .frame_len     (frame_len),
        .num_frames    (num_frames),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .stim_en       (stim_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshakes are sampled mid-cycle; inputs only change just after the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_tvalid", m_axis_tvalid, 1);
                check("hold_beat", {m_axis_tlast, m_axis_tdata}, prev_beat);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beats.push_back({m_axis_tlast, m_axis_tdata});
                check("tkeep", m_axis_tkeep, 4'hf);
            end
            if (done) begin
                done_seen++;
                check("busy_low_with_done", busy, 0);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tlast, m_axis_tdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (in_valid) in_data = in_data + 1;
    endtask

    task automatic start_run(input logic [15:0] sk, input logic [15:0] fl, input logic [15:0] nf);
        beats.delete();
        skip_len   = sk;
        frame_len  = fl;
        num_frames = nf;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        in_data = 0;
        check("stim_en_after_start", stim_en, 1);
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base = done_seen;
        for (int i = 0; i < budget && done_seen == base; i++) tick();
        for (int i = 0; i < 3; i++) tick();
        check({tag, "_done_pulses"}, done_seen - base, 1);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_stim_off"}, stim_en, 0);
    endtask

    task automatic check_beats(input string tag);
        check({tag, "_beat_count"}, beats.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), beats[i], exp_q[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b1; m_axis_tready = 1'b1;
        skip_len = 0; frame_len = 0; num_frames = 0; in_data = 0;
        repeat (3) tick();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_outputs", {stim_en, m_axis_tlast, busy, done, overflow}, 0);
        check("rst_tdata_tkeep", {m_axis_tdata, m_axis_tkeep}, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        tick();

        // 1: three frames of four after skipping two samples
        start_run(2, 4, 3);
        wait_done("t1", 100);
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back({(i % 4 == 3), 32'(i + 2)});
        check_beats("t1");
        check("t1_frame_cnt", frame_cnt, 3);
        check("t1_overflow", overflow, 0);

        // 2: sink stalled throughout capture; last beat of frame 4 lands in the reserved entry
        m_axis_tready = 1'b0;
        start_run(2, 4, 6);
        for (int i = 0; i < 100 && stim_en; i++) tick();
        repeat (4) tick();
        check("t2_stim_fell", stim_en, 0);
        check("t2_overflow", overflow, 1);
        check("t2_frame_cnt", frame_cnt, 6);
        check("t2_still_busy", busy, 1);
        check("t2_no_beats_yet", beats.size(), 0);
        m_axis_tready = 1'b1;
        wait_done("t2", 100);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back({(i % 4 == 3), 32'(i + 2)});
        check_beats("t2");

        // 3: continuous mode, abort together with the 8th sample
        start_run(0, 5, 0);
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_stim_fell", stim_en, 0);
        wait_done("t3", 100);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 4 || i == 7), 32'(i)});
        check_beats("t3");
        check("t3_frame_cnt", frame_cnt, 1);

        // 3b: abort mid-frame with no sample repeats the last pushed data as the tlast beat
        start_run(0, 4, 0);
        repeat (2) tick();
        in_valid = 1'b0;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b1;
        wait_done("t3b", 100);
        exp_q.delete();
        exp_q.push_back({1'b0, 32'd0});
        exp_q.push_back({1'b0, 32'd1});
        exp_q.push_back({1'b1, 32'd1});
        check_beats("t3b");

        // 4: abort exactly on a frame boundary adds nothing
        start_run(0, 3, 0);
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("t4", 100);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back({(i % 3 == 2), 32'(i)});
        check_beats("t4");
        check("t4_overflow", overflow, 0);

        // 5: reset with six entries queued, then a clean run
        m_axis_tready = 1'b0;
        start_run(0, 4, 0);
        repeat (6) tick();
        check("t5_queued", m_axis_tvalid, 1);
        rst = 1'b1;
        tick();
        check("t5_rst_tvalid", m_axis_tvalid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_stim", stim_en, 0);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        check("t5_fifo_empty", m_axis_tvalid, 0);
        start_run(1, 2, 2);
        wait_done("t5", 100);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({(i % 2 == 1), 32'(i + 1)});
        check_beats("t5");

        // 6: frame_len 0 behaves as 1; a start while busy is ignored
        start_run(0, 0, 3);
        repeat (2) tick();
        frame_len  = 7;
        num_frames = 9;
        start      = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6", 100);
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 32'(i)});
        check_beats("t6");
        check("t6_frame_cnt", frame_cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
